// File: rtl/hexdisplay_pkg.sv
// Shared widths, blank pattern, FSM state type and packed hex value type for the hex display scheduler.
package hexdisplay_pkg;

    localparam int unsigned NDIG_DEF = 6;
    localparam int unsigned NIB_W    = 4;
    localparam int unsigned SEG_W    = 7;
    localparam int unsigned DATA_W   = NDIG_DEF * NIB_W;
    localparam int unsigned IDX_W    = 3;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Nibble 0 is the rightmost digit.
    typedef logic [NDIG_DEF-1:0][NIB_W-1:0] hexval_t;

endpackage

// File: rtl/hexdisplay.sv
// 4-bit to seven-segment decoder, active-low segments ordered {g,f,e,d,c,b,a}.
module hexdisplay
    import hexdisplay_pkg::*;
(
    input  logic [NIB_W-1:0] hex,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (hex)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hexdisplay_sched.sv
// Two-requester (A priority) six-digit hex display scheduler: one shared decoder scans a
// latched value MSD first into shadow registers, then updates HEX0..HEX5 atomically.
// Define HEXDISPLAY_LZB_EN to enable leading-zero blanking.
module hexdisplay_sched
    import hexdisplay_pkg::*;
#(
    parameter int unsigned NDIG = NDIG_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              busy,
    output logic              done,
    output logic              src,
    output logic [SEG_W-1:0]  HEX0,
    output logic [SEG_W-1:0]  HEX1,
    output logic [SEG_W-1:0]  HEX2,
    output logic [SEG_W-1:0]  HEX3,
    output logic [SEG_W-1:0]  HEX4,
    output logic [SEG_W-1:0]  HEX5
);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    hexval_t            data_q;
    logic               src_q;
    logic [SEG_W-1:0]   shadow [NDIG_DEF];
    logic [NIB_W-1:0]   nib;
    logic [SEG_W-1:0]   seg_dec;
    logic [SEG_W-1:0]   seg_c;
    logic               xfer_a;
    logic               xfer_b;
    logic               xfer;
    logic               last;

    // Strict A priority; ready depends only on state and a_valid.
    assign a_ready = (state == IDLE);
    assign b_ready = (state == IDLE) && !a_valid;
    assign busy    = (state == SCAN);
    assign xfer_a  = a_valid && a_ready;
    assign xfer_b  = b_valid && b_ready;
    assign xfer    = xfer_a || xfer_b;
    assign last    = (idx == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer) state_nxt = SCAN;
            SCAN:    if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign nib = data_q[idx];

    hexdisplay u_dec (
        .hex (nib),
        .seg (seg_dec)
    );

`ifdef HEXDISPLAY_LZB_EN
    logic seen_nz;
    logic blank_c;

    // Blank only zeros above digit 0 with no nonzero digit seen to their left.
    assign blank_c = (nib == '0) && !last && !seen_nz;
    assign seg_c   = blank_c ? SEG_BLANK : seg_dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_nz <= 1'b0;
        end else if (state == IDLE && xfer) begin
            seen_nz <= 1'b0;
        end else if (state == SCAN && nib != '0) begin
            seen_nz <= 1'b1;
        end
    end
`else
    assign seg_c = seg_dec;
`endif

    // Scan datapath: shadow fill per digit, whole display committed on the last digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= IDX_W'(NDIG - 1);
            data_q <= '0;
            src_q  <= 1'b0;
            src    <= 1'b0;
            done   <= 1'b0;
            HEX0   <= SEG_BLANK;
            HEX1   <= SEG_BLANK;
            HEX2   <= SEG_BLANK;
            HEX3   <= SEG_BLANK;
            HEX4   <= SEG_BLANK;
            HEX5   <= SEG_BLANK;
            for (int i = 0; i < int'(NDIG_DEF); i++) begin
                shadow[i] <= SEG_BLANK;
            end
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (xfer) begin
                    data_q <= xfer_a ? hexval_t'(a_data) : hexval_t'(b_data);
                    src_q  <= !xfer_a;
                    idx    <= IDX_W'(NDIG - 1);
                end
            end else begin
                shadow[idx] <= seg_c;
                if (last) begin
                    HEX0 <= seg_c;
                    HEX1 <= shadow[1];
                    HEX2 <= shadow[2];
                    HEX3 <= shadow[3];
                    HEX4 <= shadow[4];
                    HEX5 <= shadow[5];
                    src  <= src_q;
                    done <= 1'b1;
                end else begin
                    idx <= idx - IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_hexdisplay_sched.sv
// Directed self-checking bench for hexdisplay_sched; expectations follow HEXDISPLAY_LZB_EN.
module tb_hexdisplay_sched;
    import hexdisplay_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              a_valid;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              busy;
    logic              done;
    logic              src;
    logic [6:0]        HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int checks = 0;
    int errors = 0;

    // Leading-zero digit pattern depends on the build.
`ifdef HEXDISPLAY_LZB_EN
    localparam logic [6:0] LZ = 7'h7F;
`else
    localparam logic [6:0] LZ = 7'h40;
`endif
    localparam logic [41:0] ALL_BLANK = {6{7'h7F}};

    typedef struct {
        logic        use_b;
        logic [23:0] data;
        logic [41:0] exp;   // {HEX5,...,HEX0}
    } vec_t;

    vec_t        vecs [6];
    logic [41:0] prev_hex;

    hexdisplay_sched #(.NDIG(6)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_ready (b_ready),
        .busy    (busy),
        .done    (done),
        .src     (src),
        .HEX0    (HEX0),
        .HEX1    (HEX1),
        .HEX2    (HEX2),
        .HEX3    (HEX3),
        .HEX4    (HEX4),
        .HEX5    (HEX5)
    );

    always #5 clk = ~clk;

    function automatic logic [41:0] get_hex();
        return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transfer from IDLE, checking the full scan timeline through the done cycle.
    task automatic run_xfer(input logic use_b, input logic [23:0] d,
                            input logic [41:0] exp, input string nm);
        if (use_b) begin
            b_valid = 1'b1; b_data = d;
        end else begin
            a_valid = 1'b1; a_data = d;
        end
        #1;
        if (use_b) chk({nm, " b_ready"}, 64'(b_ready), 64'd1);
        else       chk({nm, " a_ready"}, 64'(a_ready), 64'd1);
        step();
        a_valid = 1'b0;
        b_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            chk($sformatf("%s busy T+%0d", nm, k), 64'(busy), 64'd1);
            chk($sformatf("%s done T+%0d", nm, k), 64'(done), 64'd0);
            chk($sformatf("%s hold T+%0d", nm, k), 64'(get_hex()), 64'(prev_hex));
            step();
        end
        chk({nm, " done"},    64'(done),      64'd1);
        chk({nm, " busy"},    64'(busy),      64'd0);
        chk({nm, " src"},     64'(src),       64'(use_b));
        chk({nm, " hex"},     64'(get_hex()), 64'(exp));
        chk({nm, " a_ready"}, 64'(a_ready),   64'd1);
        prev_hex = exp;
        step();
        chk({nm, " pulse"},   64'(done),      64'd0);
    endtask

    initial begin
        clk     = 1'b0;
        rst_n   = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_data  = '0;
        b_data  = '0;

        vecs[0] = '{1'b1, 24'h00A1F0, {LZ, LZ, 7'h08, 7'h79, 7'h0E, 7'h40}};
        vecs[1] = '{1'b0, 24'h000000, {LZ, LZ, LZ, LZ, LZ, 7'h40}};
        vecs[2] = '{1'b0, 24'h123456, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}};
        vecs[3] = '{1'b1, 24'h0F0009, {LZ, 7'h0E, 7'h40, 7'h40, 7'h40, 7'h10}};
        vecs[4] = '{1'b0, 24'h00000E, {LZ, LZ, LZ, LZ, LZ, 7'h06}};
        vecs[5] = '{1'b1, 24'hFEDCBA, {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08}};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst hex",  64'(get_hex()), 64'(ALL_BLANK));
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst src",  64'(src),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst a_ready", 64'(a_ready), 64'd1);
        chk("rst b_ready", 64'(b_ready), 64'd1);
        step();
        prev_hex = ALL_BLANK;

        for (int i = 0; i < 6; i++) begin
            run_xfer(vecs[i].use_b, vecs[i].data, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Simultaneous requests: A first, B at T+7, B done at T+14
        a_valid = 1'b1; a_data = 24'h0000E1;
        b_valid = 1'b1; b_data = 24'h00A1F0;
        #1;
        chk("sim a_ready", 64'(a_ready), 64'd1);
        chk("sim b_ready", 64'(b_ready), 64'd0);
        step();
        a_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            chk($sformatf("sim b_held T+%0d", k), 64'(b_ready), 64'd0);
            step();
        end
        chk("sim a done",  64'(done), 64'd1);
        chk("sim a src",   64'(src),  64'd0);
        chk("sim a hex",   64'(get_hex()), 64'({LZ, LZ, LZ, LZ, 7'h06, 7'h79}));
        chk("sim b_ready", 64'(b_ready), 64'd1);
        step();
        b_valid = 1'b0;
        for (int k = 8; k <= 13; k++) begin
            chk($sformatf("sim b busy T+%0d", k), 64'(busy), 64'd1);
            chk($sformatf("sim b done T+%0d", k), 64'(done), 64'd0);
            step();
        end
        chk("sim b done", 64'(done), 64'd1);
        chk("sim b src",  64'(src),  64'd1);
        chk("sim b hex",  64'(get_hex()), 64'({LZ, LZ, 7'h08, 7'h79, 7'h0E, 7'h40}));
        step();

        // Reset mid-scan at T+3
        a_valid = 1'b1; a_data = 24'h123456;
        step();
        a_valid = 1'b0;
        step();
        step();
        chk("mid busy T+3", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid hex",  64'(get_hex()), 64'(ALL_BLANK));
        chk("mid busy", 64'(busy), 64'd0);
        chk("mid src",  64'(src),  64'd0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("mid no done %0d", k), 64'(done), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid a_ready", 64'(a_ready), 64'd1);
        chk("mid b_ready", 64'(b_ready), 64'd1);
        step();
        chk("mid hex idle", 64'(get_hex()), 64'(ALL_BLANK));
        prev_hex = ALL_BLANK;
        run_xfer(1'b1, 24'h00A1F0, {LZ, LZ, 7'h08, 7'h79, 7'h0E, 7'h40}, "post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
